// File: rtl/pool_pkg.sv
// Shared definitions for the pool2 sequencer: state_RF_OUT codes decoded by the pooler,
// the sequencer FSM encoding and default datapath geometry.
package pool_pkg;

  localparam int DW_DEF  = 28;
  localparam int NPE_DEF = 14;

  localparam logic [2:0] ST_IDLE        = 3'b000;
  localparam logic [2:0] ST_OUT_TO_RELU = 3'b100;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAITD,
    S_WRITE,
    S_GAP,
    S_DRAIN,
    S_ALIGN,
    S_FIN
  } seq_state_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/pool_seq_ctrl_if.sv
// Buffer-read and pooler-side signals of the pool2 sequencer.
// master = sequencer, slave = buffer/pooler environment.
interface pool_seq_ctrl_if
  import pool_pkg::*;
#(
  parameter int DW     = DW_DEF,
  parameter int NPE    = NPE_DEF,
  parameter int ADDR_W = 10
);
  logic                GB_OUT_ready;
  logic                rd_req;
  logic [ADDR_W-1:0]   rd_addr;
  logic                rd_valid;
  logic [DW*NPE-1:0]   rd_data;
  logic [DW*NPE-1:0]   pool_data;
  logic                pool_write_en;
  logic [4:0]          pool_fl;
  logic [2:0]          state_RF_OUT;
  logic                pool_ready;

  modport master (
    input  GB_OUT_ready, rd_valid, rd_data, pool_ready,
    output rd_req, rd_addr, pool_data, pool_write_en, pool_fl, state_RF_OUT
  );

  modport slave (
    output GB_OUT_ready, rd_valid, rd_data, pool_ready,
    input  rd_req, rd_addr, pool_data, pool_write_en, pool_fl, state_RF_OUT
  );
endinterface

// File: rtl/pool_addr_gen.sv
// Row/channel counters and buffer address adder for the pool2 sequencer.
// The channel offset is accumulated instead of multiplied.
module pool_addr_gen #(
  parameter int ADDR_W = 10,
  parameter int CNT_W  = 8
)(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              inc_row,
  input  logic              next_ch,
  input  logic [ADDR_W-1:0] base,
  input  logic [CNT_W-1:0]  rows_eff,
  input  logic [CNT_W-1:0]  chans,
  output logic [ADDR_W-1:0] addr,
  output logic              row_last,
  output logic              ch_last
);
  logic [CNT_W-1:0]  r_row;
  logic [CNT_W-1:0]  r_ch;
  logic [ADDR_W-1:0] r_ch_off;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_row    <= '0;
      r_ch     <= '0;
      r_ch_off <= '0;
    end else if (clear) begin
      r_row    <= '0;
      r_ch     <= '0;
      r_ch_off <= '0;
    end else if (next_ch) begin
      r_row    <= '0;
      r_ch     <= r_ch + CNT_W'(1);
      r_ch_off <= r_ch_off + ADDR_W'(rows_eff);
    end else if (inc_row && !row_last) begin
      r_row    <= r_row + CNT_W'(1);
    end
  end

  // row_last means every row of the channel has been written
  assign row_last = (r_row == rows_eff);
  assign ch_last  = (r_ch == chans - CNT_W'(1));
  assign addr     = base + r_ch_off + ADDR_W'(r_row);
endmodule

// File: rtl/pool_seq_ctrl.sv
// Sequencer for the 2x2 max-pool/ReLU datapath: fetches row pairs from the output buffer,
// feeds the pooler, spaces pairs for its packer and opens/closes each channel.
module pool_seq_ctrl
  import pool_pkg::*;
#(
  parameter int DW       = DW_DEF,
  parameter int NPE      = NPE_DEF,
  parameter int ADDR_W   = 10,
  parameter int CNT_W    = 8,
  parameter int PAIR_GAP = 6,
  parameter int DRAIN    = 6
)(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] cfg_base,
  input  logic [CNT_W-1:0]  cfg_rows,
  input  logic [CNT_W-1:0]  cfg_chans,
  input  logic [4:0]        cfg_fl,
  pool_seq_ctrl_if.master   bus,
  output logic              busy,
  output logic              done,
  output logic [15:0]       pairs_done,
  output logic              err
);
  seq_state_e        r_state, w_next;
  logic [ADDR_W-1:0] r_base;
  logic [CNT_W-1:0]  r_rows_eff, r_chans;
  logic [4:0]        r_fl;
  logic [7:0]        r_cnt, w_cnt_val;
  logic              w_cnt_load;
  logic              r_parity, r_align_pend, r_err;
  logic [DW*NPE-1:0] r_pool_data;
  logic [15:0]       r_pairs;
  logic              w_start_go, w_abort_go, w_rd_req, w_wr, w_latch;
  logic              w_inc_row, w_next_ch, w_gap_first, w_err_ev;
  logic [ADDR_W-1:0] w_addr;
  logic              w_row_last, w_ch_last;
  logic [CNT_W-1:0]  w_cfg_rows_eff;

  assign w_cfg_rows_eff = cfg_rows & ~CNT_W'(1);
  assign w_start_go     = start && (r_state == S_IDLE);
  // ALIGN is already heading to IDLE and must still emit its realigning write
  assign w_abort_go     = abort && (r_state != S_IDLE) && (r_state != S_ALIGN);
  assign w_gap_first    = (r_state == S_GAP) && (r_cnt == 8'(PAIR_GAP));
  // The pooler answers the ALIGN write one cycle later, outside GAP; that reply is expected
  assign w_err_ev       = (w_gap_first && !bus.pool_ready) ||
                          (bus.pool_ready && !w_gap_first && !r_align_pend);

  pool_addr_gen #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) u_addr_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (w_start_go),
    .inc_row  (w_inc_row),
    .next_ch  (w_next_ch),
    .base     (r_base),
    .rows_eff (r_rows_eff),
    .chans    (r_chans),
    .addr     (w_addr),
    .row_last (w_row_last),
    .ch_last  (w_ch_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_cnt_load = 1'b0;
    w_cnt_val  = 8'd0;
    w_rd_req   = 1'b0;
    w_wr       = 1'b0;
    w_latch    = 1'b0;
    w_inc_row  = 1'b0;
    w_next_ch  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (w_cfg_rows_eff == '0 || cfg_chans == '0) w_next = S_FIN;
          else                                         w_next = S_FETCH;
        end
      end
      S_FETCH: begin
        if (bus.GB_OUT_ready) begin
          w_rd_req = 1'b1;
          w_next   = S_WAITD;
        end
      end
      S_WAITD: begin
        if (bus.rd_valid) begin
          w_latch = 1'b1;
          w_next  = S_WRITE;
        end
      end
      S_WRITE: begin
        w_wr      = 1'b1;
        w_inc_row = 1'b1;
        if (r_parity) begin
          w_next     = S_GAP;
          w_cnt_load = 1'b1;
          w_cnt_val  = 8'(PAIR_GAP);
        end else begin
          w_next = S_FETCH;
        end
      end
      S_GAP: begin
        if (r_cnt == 8'd1) begin
          if (w_row_last) begin
            w_next     = S_DRAIN;
            w_cnt_load = 1'b1;
            w_cnt_val  = 8'(DRAIN);
          end else begin
            w_next = S_FETCH;
          end
        end
      end
      S_DRAIN: begin
        if (r_cnt == 8'd1) begin
          w_next_ch = 1'b1;
          w_next    = w_ch_last ? S_FIN : S_FETCH;
        end
      end
      S_ALIGN: begin
        w_wr   = 1'b1;
        w_next = S_IDLE;
      end
      S_FIN:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (w_abort_go) begin
      w_next     = r_parity ? S_ALIGN : S_IDLE;
      w_cnt_load = 1'b0;
      w_rd_req   = 1'b0;
      w_wr       = 1'b0;
      w_latch    = 1'b0;
      w_inc_row  = 1'b0;
      w_next_ch  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_base       <= '0;
      r_rows_eff   <= '0;
      r_chans      <= '0;
      r_fl         <= '0;
      r_cnt        <= '0;
      r_parity     <= 1'b0;
      r_align_pend <= 1'b0;
      r_pool_data  <= '0;
      r_pairs      <= '0;
      r_err        <= 1'b0;
    end else begin
      if (w_start_go) begin
        r_base     <= cfg_base;
        r_rows_eff <= w_cfg_rows_eff;
        r_chans    <= cfg_chans;
        r_fl       <= cfg_fl;
      end
      if (w_cnt_load)         r_cnt <= w_cnt_val;
      else if (r_cnt != 8'd0) r_cnt <= r_cnt - 8'd1;
      if (w_wr) r_parity <= ~r_parity;
      r_align_pend <= (r_state == S_ALIGN);
      if (w_latch)                  r_pool_data <= bus.rd_data;
      else if (w_abort_go && r_parity) r_pool_data <= '0;
      if (w_start_go)                          r_pairs <= '0;
      else if (w_gap_first && bus.pool_ready)  r_pairs <= sat_inc16(r_pairs);
      if (w_start_go)    r_err <= 1'b0;
      else if (w_err_ev) r_err <= 1'b1;
    end
  end

  assign bus.rd_req        = w_rd_req;
  assign bus.rd_addr       = w_addr;
  assign bus.pool_data     = r_pool_data;
  assign bus.pool_write_en = w_wr;
  assign bus.pool_fl       = r_fl;
  assign bus.state_RF_OUT  = (r_state == S_FETCH || r_state == S_WAITD ||
                              r_state == S_WRITE || r_state == S_GAP) ? ST_OUT_TO_RELU : ST_IDLE;
  assign busy       = (r_state != S_IDLE);
  assign done       = (r_state == S_FIN) && !w_abort_go;
  assign pairs_done = r_pairs;
  assign err        = r_err;
endmodule

// File: doc/pool_seq_ctrl.md
Name: pool_seq_ctrl

Overview:
- Sequencer for the 2x2 max-pool/ReLU datapath (pool2).
- Fetches 14-lane partial-sum rows (28 b/lane) from the output global buffer and presents them to the pooler in row pairs, one pool_write_en per row.
- Spaces pairs so the pooler's 4-cycle compaction packer can finish, and drives state_RF_OUT to open and close each channel (the close triggers the packer's zero-flush).
- Reports progress, completion and a pooler-handshake error.

Parameters:
DW, 28, bits per lane of partial sum
NPE, 14, lanes per row
ADDR_W, 10, buffer row address width
CNT_W, 8, width of the row and channel configuration counts
PAIR_GAP, 6, minimum cycles from the second write of a pair to the next fetch
DRAIN, 6, cycles state_RF_OUT is held non-OUT_TO_ReLU after a channel's last pair

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle start pulse; honoured only in IDLE
abort  in  1  synchronous abort request
cfg_base  in  ADDR_W  first buffer row address
cfg_rows  in  CNT_W  rows per channel; bit 0 is ignored (count rounded down to even)
cfg_chans  in  CNT_W  number of channels
cfg_fl  in  5  fraction length passed to the pooler
GB_OUT_ready  in  1  output global buffer can accept; a fetch may issue only while high
rd_req  out  1  one-cycle buffer read strobe
rd_addr  out  ADDR_W  read address; valid with rd_req
rd_valid  in  1  read data valid; any latency of 1 cycle or more
rd_data  in  DW*NPE  row data
pool_data  out  DW*NPE  held row presented to the pooler
pool_write_en  out  1  one-cycle write strobe to the pooler
pool_fl  out  5  latched cfg_fl
state_RF_OUT  out  3  ST_OUT_TO_RELU while a channel is active, otherwise ST_IDLE
pool_ready  in  1  pooler output-valid pulse
busy  out  1  high whenever the FSM is not in IDLE
done  out  1  one-cycle completion pulse
pairs_done  out  16  pairs completed since start
err  out  1  sticky handshake error; cleared by start

Behaviour:
- Reset: FSM to IDLE, all outputs 0, except state_RF_OUT = ST_IDLE; internal parity = 0.
- start in IDLE:
  - latches all cfg_* and clears pairs_done and err;
  - if rows_eff = cfg_rows & ~1 is 0, or cfg_chans is 0: done pulses the next cycle and the FSM returns to IDLE.
  - start while busy is ignored.
- States: IDLE, FETCH, WAITD, WRITE, GAP, DRAIN, ALIGN, FIN.
- FETCH: state_RF_OUT = ST_OUT_TO_RELU. When GB_OUT_ready = 1, pulse rd_req with rd_addr = base + ch*rows_eff + row (mod 2^ADDR_W), then go to WAITD. When GB_OUT_ready = 0, stall.
- WAITD: on rd_valid, latch rd_data into pool_data and go to WRITE. rd_valid in any other state is ignored.
- WRITE: pulse pool_write_en for one cycle, increment row, toggle parity.
  - Parity was 0: go to FETCH.
  - Parity was 1: go to GAP with a counter loaded to PAIR_GAP.
- GAP:
  - pool_ready must arrive exactly 1 cycle after the second write; if it is absent, set err.
  - On pool_ready, pairs_done += 1.
  - When the counter expires: go to FETCH if rows remain in the channel; otherwise go to DRAIN.
- DRAIN: state_RF_OUT = ST_IDLE for DRAIN cycles, then ch += 1 and row = 0.
  - Next state is FETCH if channels remain, otherwise FIN.
  - On entering FETCH, state_RF_OUT returns to ST_OUT_TO_RELU; this rising edge resets the pooler packer.
- FIN: done = 1 for one cycle, then IDLE.
- Latency per pair: 2 fetch and write loops (each 1 + read latency + 1 cycles), plus PAIR_GAP.
- abort:
  - Honoured in any non-IDLE state and has priority over all other transitions.
  - Parity 0: go to IDLE next cycle.
  - Parity 1: go to ALIGN, which issues one pool_write_en with pool_data = 0 to realign the pooler's write toggle, then IDLE.
  - No done pulse on abort; state_RF_OUT = ST_IDLE.
- Simultaneous events:
  - abort and start in the same cycle in IDLE: start wins.
  - pool_ready outside GAP: sets err.
- The row counter never exceeds rows_eff. pairs_done saturates at 16'hFFFF.
- Asynchronous reset mid-operation: immediate return to the reset values above. The pooler shares rst_n, so parity stays consistent with it.

Decomposition:
- Shared package pool_pkg holds:
  - state_RF_OUT codes ST_IDLE = 3'b000 and ST_OUT_TO_RELU = 3'b100 (the same codes the pooler decodes);
  - FSM state enumeration;
  - DW and NPE defaults.
- One natural sub-module, pool_addr_gen: base/row/channel counters plus the address adder, with inc_row, next_ch and clear controls and row_last / ch_last outputs.

Test Plan:
1. base=0x010, rows=4, chans=1, 1-cycle read latency, pooler model responding -> 4 rd_req at 0x010..0x013, 4 write strobes, pairs_done=2, state_RF_OUT low for 6 cycles after the last GAP, done once, err=0.
2. base=0x3FE, rows=2, chans=2 -> addresses 0x3FE, 0x3FF, 0x000, 0x001 (wrap), with a ST_IDLE→ST_OUT_TO_RELU transition before channel 2.
3. GB_OUT_ready held low for 10 cycles during FETCH -> no rd_req while low; fetch issues the first cycle it rises; data order unchanged.
4. rows=5 -> rows_eff=4 and exactly 4 fetches; rows=1 or chans=0 -> done 1 cycle after start, no rd_req.
5. abort after the first write of a pair -> exactly one pool_write_en with pool_data=0, then IDLE with busy=0 and no done. A subsequent start runs cleanly with err=0.
6. Pooler model withholds pool_ready after a pair -> err=1 stays set through done; the next start clears it.
